// File: rtl/gate_sweep_eval.sv
// Sweeps every N-bit input vector through X = IN[N-1] & ~^IN[N-2:0] and captures the truth table and ones count.
// Optional first-mismatch checker against an expected table: define GATE_SWEEP_MISMATCH_CHECK_EN.
module gate_sweep_eval #(
    parameter int N           = 3,
    parameter int STEP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
    input  logic [2**N-1:0]   exp_tt,
    output logic              mismatch,
    output logic [N-1:0]      fail_idx,
`endif
    output logic [N-1:0]      vec,
    output logic              x_out,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   tt,
    output logic [N:0]        ones_cnt
);

    localparam int NV = 2**N;
    localparam int HW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(STEP_CYCLES - 1);
    localparam logic [N-1:0]  VEC_LAST  = '1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    vec_reg;
    logic [HW-1:0]   hold_reg;
    logic [NV-1:0]   tt_reg, tt_next;
    logic [N:0]      ones_reg;
    logic            accept;
    logic            sample;

    // ABORT beats START in IDLE, and discards the sample due on its edge in RUN.
    assign accept = (state_reg == IDLE) && start && !abort;
    assign sample = valid && !abort;

    assign x_out    = vec_reg[N-1] & ~(^vec_reg[N-2:0]);
    assign vec      = vec_reg;
    assign tt       = tt_reg;
    assign ones_cnt = ones_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (valid && (vec_reg == VEC_LAST)) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_reg == RUN);
        done  = (state_reg == FIN);
        valid = (state_reg == RUN) && (hold_reg == HOLD_LAST);
    end

    // Each truth-table bit owns its own write-enable decode.
    for (genvar gi = 0; gi < NV; gi++) begin : g_tt
        localparam logic [N-1:0] IDX = N'(gi);
        assign tt_next[gi] = accept ? 1'b0 :
                             (sample && (vec_reg == IDX)) ? x_out : tt_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tt_reg <= '0;
        end else begin
            tt_reg <= tt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vec_reg  <= '0;
            hold_reg <= '0;
            ones_reg <= '0;
        end else if (accept) begin
            vec_reg  <= '0;
            hold_reg <= '0;
            ones_reg <= '0;
        end else if ((state_reg == RUN) && !abort) begin
            if (valid) begin
                hold_reg <= '0;
                ones_reg <= ones_reg + {{N{1'b0}}, x_out};
                if (vec_reg != VEC_LAST) begin
                    vec_reg <= vec_reg + 1'b1;
                end
            end else begin
                hold_reg <= hold_reg + 1'b1;
            end
        end
    end

`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
    logic          mismatch_reg;
    logic [N-1:0]  fail_idx_reg;

    // Only the first disagreement of a sweep records its index.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mismatch_reg <= 1'b0;
            fail_idx_reg <= '0;
        end else if (accept) begin
            mismatch_reg <= 1'b0;
            fail_idx_reg <= '0;
        end else if (sample && (x_out != exp_tt[vec_reg])) begin
            mismatch_reg <= 1'b1;
            if (!mismatch_reg) begin
                fail_idx_reg <= vec_reg;
            end
        end
    end

    assign mismatch = mismatch_reg;
    assign fail_idx = fail_idx_reg;
`endif

endmodule

// File: tb/tb_gate_sweep_eval.sv
// Scoreboard bench for gate_sweep_eval: three configurations (N=3/S=1, N=3/S=3, N=4/S=1).
module tb_gate_sweep_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic start_a, abort_a, start_b, abort_b, start_c, abort_c;
    logic [2:0]  vec_a, vec_b;
    logic [3:0]  vec_c;
    logic        x_a, x_b, x_c, valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [7:0]  tt_a, tt_b;
    logic [15:0] tt_c;
    logic [3:0]  ones_a, ones_b;
    logic [4:0]  ones_c;
`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
    logic [7:0]  exp_a, exp_b;
    logic [15:0] exp_c;
    logic        mm_a, mm_b, mm_c;
    logic [2:0]  fi_a, fi_b;
    logic [3:0]  fi_c;
`endif

    gate_sweep_eval #(.N(3), .STEP_CYCLES(1)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .abort(abort_a),
`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
        .exp_tt(exp_a), .mismatch(mm_a), .fail_idx(fi_a),
`endif
        .vec(vec_a), .x_out(x_a), .valid(valid_a), .busy(busy_a), .done(done_a),
        .tt(tt_a), .ones_cnt(ones_a)
    );

    gate_sweep_eval #(.N(3), .STEP_CYCLES(3)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b),
`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
        .exp_tt(exp_b), .mismatch(mm_b), .fail_idx(fi_b),
`endif
        .vec(vec_b), .x_out(x_b), .valid(valid_b), .busy(busy_b), .done(done_b),
        .tt(tt_b), .ones_cnt(ones_b)
    );

    gate_sweep_eval #(.N(4), .STEP_CYCLES(1)) dut_c (
        .clk(clk), .rstn(rstn), .start(start_c), .abort(abort_c),
`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
        .exp_tt(exp_c), .mismatch(mm_c), .fail_idx(fi_c),
`endif
        .vec(vec_c), .x_out(x_c), .valid(valid_c), .busy(busy_c), .done(done_c),
        .tt(tt_c), .ones_cnt(ones_c)
    );

    typedef struct { int v; int x; } vexp_t;
    typedef struct { longint tt; int ones; } dexp_t;

    vexp_t vq_a[$], vq_b[$], vq_c[$];
    dexp_t dq_a[$], dq_b[$], dq_c[$];
    vexp_t ea, eb, ec;
    dexp_t da, db, dc;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop an expectation whenever a DUT presents a sample or a done pulse.
    always @(negedge clk) begin
        if (valid_a) begin
            if (vq_a.size() == 0) check("a_unexpected_valid", 1, 0);
            else begin
                ea = vq_a.pop_front();
                check("a_vec", vec_a, ea.v);
                check("a_x", x_a, ea.x);
            end
        end
        if (done_a) begin
            if (dq_a.size() == 0) check("a_unexpected_done", 1, 0);
            else begin
                da = dq_a.pop_front();
                check("a_tt", tt_a, da.tt);
                check("a_ones", ones_a, da.ones);
                $display("sweep a: tt=%h ones=%0d", tt_a, ones_a);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (vq_b.size() == 0) check("b_unexpected_valid", 1, 0);
            else begin
                eb = vq_b.pop_front();
                check("b_vec", vec_b, eb.v);
                check("b_x", x_b, eb.x);
            end
        end
        if (done_b) begin
            if (dq_b.size() == 0) check("b_unexpected_done", 1, 0);
            else begin
                db = dq_b.pop_front();
                check("b_tt", tt_b, db.tt);
                check("b_ones", ones_b, db.ones);
                $display("sweep b: tt=%h ones=%0d", tt_b, ones_b);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_c) begin
            if (vq_c.size() == 0) check("c_unexpected_valid", 1, 0);
            else begin
                ec = vq_c.pop_front();
                check("c_vec", vec_c, ec.v);
                check("c_x", x_c, ec.x);
            end
        end
        if (done_c) begin
            if (dq_c.size() == 0) check("c_unexpected_done", 1, 0);
            else begin
                dc = dq_c.pop_front();
                check("c_tt", tt_c, dc.tt);
                check("c_ones", ones_c, dc.ones);
                $display("sweep c: tt=%h ones=%0d", tt_c, ones_c);
            end
        end
    end

    function automatic bit dn(input int s);
        case (s)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic bit bs(input int s);
        case (s)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic bit vl(input int s);
        case (s)
            0: return valid_a;
            1: return valid_b;
            default: return valid_c;
        endcase
    endfunction

    function automatic longint ttv(input int s);
        case (s)
            0: return longint'(tt_a);
            1: return longint'(tt_b);
            default: return longint'(tt_c);
        endcase
    endfunction

    function automatic int onesv(input int s);
        case (s)
            0: return int'(ones_a);
            1: return int'(ones_b);
            default: return int'(ones_c);
        endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Expected sample stream taken from a hand-computed truth table constant.
    task automatic push_sweep(input int s, input longint ttexp, input int upto,
                              input bit with_done, input int ones);
        vexp_t e;
        dexp_t d;
        for (int v = 0; v <= upto; v++) begin
            e.v = v;
            e.x = int'((ttexp >> v) & 1);
            case (s)
                0: vq_a.push_back(e);
                1: vq_b.push_back(e);
                default: vq_c.push_back(e);
            endcase
        end
        if (with_done) begin
            d.tt   = ttexp;
            d.ones = ones;
            case (s)
                0: dq_a.push_back(d);
                1: dq_b.push_back(d);
                default: dq_c.push_back(d);
            endcase
        end
    endtask

    task automatic run_sweep(input int s, input int limit, input int exp_cyc,
                             input int exp_busy, input int exp_valid,
                             input bit glitch, input bit chk_clear);
        int cyc, busy_n, valid_n;
        @(negedge clk); set_start(s, 1'b1);
        @(negedge clk); set_start(s, 1'b0);
        if (chk_clear) begin
            check("restart_tt_clear", ttv(s), 0);
            check("restart_ones_clear", onesv(s), 0);
        end
        cyc = 1; busy_n = 0; valid_n = 0;
        while (!dn(s) && cyc < limit) begin
            if (bs(s)) busy_n++;
            if (vl(s)) valid_n++;
            if (glitch && cyc == 3) set_start(s, 1'b1);
            if (glitch && cyc == 4) set_start(s, 1'b0);
            @(negedge clk);
            cyc++;
        end
        check("done_latency", cyc, exp_cyc);
        check("busy_cycles", busy_n, exp_busy);
        check("valid_cycles", valid_n, exp_valid);
        check("busy_in_fin", bs(s), 0);
        if (glitch) set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        check("done_one_cycle", dn(s), 0);
        check("idle_after_fin", bs(s), 0);
        @(negedge clk);
        check("fin_start_ignored", bs(s), 0);
    endtask

    initial begin
        int cnt;
        rstn = 1'b0;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; start_c = 0; abort_c = 0;
`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
        exp_a = 8'h90; exp_b = 8'h90; exp_c = 16'h6900;
`endif
        repeat (2) @(negedge clk);
        check("rst_vec_a", vec_a, 0);
        check("rst_tt_a", tt_a, 0);
        check("rst_ones_a", ones_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_valid_b", valid_b, 0);
        check("rst_tt_c", tt_c, 0);
        rstn = 1'b1;

        // Basic sweeps for each configuration.
        push_sweep(0, 64'h90, 7, 1, 2);
        run_sweep(0, 100, 9, 8, 8, 0, 0);
        repeat (3) @(negedge clk);
        check("a_tt_hold", tt_a, 8'h90);
        check("a_ones_hold", ones_a, 2);

        push_sweep(1, 64'h90, 7, 1, 2);
        run_sweep(1, 200, 25, 24, 8, 0, 0);

        push_sweep(2, 64'h6900, 15, 1, 4);
        run_sweep(2, 100, 17, 16, 16, 0, 0);
        push_sweep(2, 64'h6900, 15, 1, 4);
        run_sweep(2, 100, 17, 16, 16, 0, 1);

        // START pulses inside RUN and inside FIN must be ignored.
        push_sweep(0, 64'h90, 7, 1, 2);
        run_sweep(0, 100, 9, 8, 8, 1, 0);

        // Abort while vector 5 is being presented.
        push_sweep(0, 64'h90, 5, 0, 0);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        cnt = 0;
        while (vec_a != 3'd5 && cnt < 50) begin @(negedge clk); cnt++; end
        check("abort_reach_vec5", vec_a, 5);
        check("abort_valid_high", valid_a, 1);
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_tt", tt_a, 8'h10);
        check("abort_ones", ones_a, 1);
        check("abort_vec", vec_a, 5);
        repeat (3) @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
        check("start_abort_busy", busy_a, 0);
        @(negedge clk);
        check("start_abort_busy2", busy_a, 0);
        check("start_abort_tt", tt_a, 8'h10);

        // Reset in the middle of a sweep.
        push_sweep(0, 64'h90, 3, 0, 0);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        cnt = 0;
        while (vec_a != 3'd3 && cnt < 50) begin @(negedge clk); cnt++; end
        check("rst_run_reach_vec3", vec_a, 3);
        rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        check("rst_run_vec", vec_a, 0);
        check("rst_run_x", x_a, 0);
        check("rst_run_tt", tt_a, 0);
        check("rst_run_ones", ones_a, 0);
        check("rst_run_busy", busy_a, 0);
        check("rst_run_valid", valid_a, 0);
        repeat (2) @(negedge clk);
        check("rst_run_stays_idle", busy_a, 0);

`ifdef GATE_SWEEP_MISMATCH_CHECK_EN
        exp_a = 8'h91;
        push_sweep(0, 64'h90, 7, 1, 2);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        check("mm_set_at_v0", mm_a, 1);
        check("mm_idx_v0", fi_a, 0);
        cnt = 0;
        while (!done_a && cnt < 50) begin @(negedge clk); cnt++; end
        check("mm_done_seen", done_a, 1);
        @(negedge clk);
        check("mm_persist", mm_a, 1);
        check("mm_idx_persist", fi_a, 0);
        exp_a = 8'h90;
        push_sweep(0, 64'h90, 7, 1, 2);
        run_sweep(0, 100, 9, 8, 8, 0, 0);
        check("mm_clear_match", mm_a, 0);
`endif

        repeat (2) @(negedge clk);
        check("a_valid_queue_empty", vq_a.size(), 0);
        check("a_done_queue_empty", dq_a.size(), 0);
        check("b_valid_queue_empty", vq_b.size(), 0);
        check("b_done_queue_empty", dq_b.size(), 0);
        check("c_valid_queue_empty", vq_c.size(), 0);
        check("c_done_queue_empty", dq_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
